// File: rtl/c3_dispatch_wb.sv
// Core-side issue/writeback bridge for the C3 custom instruction unit.
// Optional rd scoreboard enabled by defining C3_DISPATCH_SCOREBOARD_EN.
module c3_dispatch_wb #(
  parameter int unsigned PIPE_CYCLES     = 5,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned HEAP_GAP        = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_data,
  output logic        c3_in_v,
  output logic        c3_push,
  output logic        c3_pop,
  output logic [4:0]  c3_rd,
  output logic [31:0] c3_in_data,
  input  logic        c3_out_v,
  input  logic [4:0]  c3_out_rd,
  input  logic [31:0] c3_out_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] busy_mask,
  output logic        err_unexpected
);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned GW = (HEAP_GAP > 0) ? $clog2(HEAP_GAP + 1) : 1;
  localparam logic [OW-1:0] MAX_O    = OW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(HEAP_GAP);

  logic [OW-1:0] outst;
  logic [GW-1:0] gap_cnt;
  logic [OW-1:0] fifo_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    mem_rd   [MAX_OUTSTANDING];
  logic [31:0]   mem_data [MAX_OUTSTANDING];

  logic heap_op, accept, wb_hs, res_in, res_drop, fifo_wr, sb_hit;

  assign heap_op  = (req_op == 2'b01) || (req_op == 2'b10);
  assign req_ready = (outst < MAX_O) && !sb_hit && !(heap_op && (gap_cnt != '0));
  assign accept   = req_valid && req_ready;
  assign wb_valid = (fifo_cnt != '0);
  assign wb_hs    = wb_valid && wb_ready;
  assign wb_rd    = mem_rd[rd_ptr];
  assign wb_data  = mem_data[rd_ptr];
  // Results arriving with nothing outstanding (e.g. stale after reset) are discarded.
  assign res_in   = c3_out_v && (outst != '0);
  assign res_drop = res_in && (c3_out_rd == '0);
  assign fifo_wr  = res_in && (c3_out_rd != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c3_in_v    <= 1'b0;
      c3_push    <= 1'b0;
      c3_pop     <= 1'b0;
      c3_rd      <= '0;
      c3_in_data <= '0;
    end else begin
      c3_in_v <= accept;
      c3_push <= accept && (req_op == 2'b01);
      c3_pop  <= accept && (req_op == 2'b10);
      if (accept) begin
        c3_rd      <= req_rd;
        c3_in_data <= req_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outst          <= '0;
      gap_cnt        <= '0;
      err_unexpected <= 1'b0;
    end else begin
      outst <= outst + OW'(accept) - OW'(wb_hs) - OW'(res_drop);
      if (accept && heap_op)
        gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
      if (c3_out_v && (outst == '0))
        err_unexpected <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      fifo_cnt <= fifo_cnt + OW'(fifo_wr) - OW'(wb_hs);
      if (fifo_wr)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (wb_hs)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_rd[wr_ptr]   <= c3_out_rd;
      mem_data[wr_ptr] <= c3_out_data;
    end
  end

`ifdef C3_DISPATCH_SCOREBOARD_EN
  logic [31:0] busy_q, sb_set, sb_clr;

  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (accept && (req_rd != '0))
      sb_set[req_rd] = 1'b1;
    if (wb_hs)
      sb_clr[wb_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_q <= '0;
    else
      busy_q <= (busy_q | sb_set) & ~sb_clr;
  end

  assign sb_hit    = busy_q[req_rd];
  assign busy_mask = busy_q;
`else
  assign sb_hit    = 1'b0;
  assign busy_mask = '0;
`endif

endmodule

// File: tb/tb_c3_dispatch_wb.sv
// Directed bench for c3_dispatch_wb with a fixed-latency C3 model (result = 2 * operand).
module tb_c3_dispatch_wb;
  localparam int unsigned P = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] req_data = '0;
  logic        c3_in_v, c3_push, c3_pop;
  logic [4:0]  c3_rd;
  logic [31:0] c3_in_data;
  logic        c3_out_v;
  logic [4:0]  c3_out_rd;
  logic [31:0] c3_out_data;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] busy_mask;
  logic        err_unexpected;

  logic        inj_v = 1'b0;
  logic [4:0]  inj_rd = '0;
  logic [31:0] inj_data = '0;

  int errors = 0;
  int checks = 0;
  int n;
  int lat;
  logic seen;

  always #5 clk = ~clk;

  c3_dispatch_wb #(.PIPE_CYCLES(P), .MAX_OUTSTANDING(4), .HEAP_GAP(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_data(req_data),
    .c3_in_v(c3_in_v), .c3_push(c3_push), .c3_pop(c3_pop),
    .c3_rd(c3_rd), .c3_in_data(c3_in_data),
    .c3_out_v(c3_out_v), .c3_out_rd(c3_out_rd), .c3_out_data(c3_out_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_mask(busy_mask), .err_unexpected(err_unexpected)
  );

  logic [P-1:0] mv;
  logic [4:0]   mrd [P];
  logic [31:0]  md  [P];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mv <= '0;
    end else begin
      mv     <= {mv[P-2:0], c3_in_v};
      mrd[0] <= c3_rd;
      md[0]  <= c3_in_data * 2;
      for (int i = 1; i < P; i++) begin
        mrd[i] <= mrd[i-1];
        md[i]  <= md[i-1];
      end
    end
  end

  assign c3_out_v    = mv[P-1] | inj_v;
  assign c3_out_rd   = inj_v ? inj_rd : mrd[P-1];
  assign c3_out_data = inj_v ? inj_data : md[P-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_wb(input int budget, output int cnt);
    cnt = 0;
    while (wb_valid !== 1'b1 && cnt < budget) begin
      tick();
      cnt++;
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] data);
    req_valid = 1'b1;
    req_op    = op;
    req_rd    = rd;
    req_data  = data;
  endtask

  initial begin
    // reset values, observed before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_in_v", c3_in_v, 0);
    chk("rst_push", c3_push, 0);
    chk("rst_pop", c3_pop, 0);
    chk("rst_rd", c3_rd, 0);
    chk("rst_data", c3_in_data, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_err", err_unexpected, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_ready", req_ready, 1);
    tick();
    tick();
    reset = 1'b0;

    // single plain op
    drive(2'b00, 5'd5, 32'h11);
    chk("single_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    lat = 1;
    chk("single_in_v", c3_in_v, 1);
    chk("single_c3_rd", c3_rd, 5);
    chk("single_c3_data", c3_in_data, 32'h11);
    tick();
    lat++;
    chk("single_in_v_pulse", c3_in_v, 0);
    wait_wb(20, n);
    lat += n;
    chk("single_wb_valid", wb_valid, 1);
    chk("single_latency", lat, 7);
    chk("single_wb_rd", wb_rd, 5);
    chk("single_wb_data", wb_data, 32'h22);
    tick();
    chk("single_wb_done", wb_valid, 0);
    chk("single_outst", dut.outst, 0);

    // credit limit
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(2'b00, 5'(i), 32'(i));
      chk("credit_ready", req_ready, 1);
      tick();
    end
    drive(2'b00, 5'd5, 32'd5);
    chk("credit_stall", req_ready, 0);
    repeat (6) tick();
    chk("credit_stall_full", req_ready, 0);
    chk("credit_wb_valid", wb_valid, 1);
    chk("credit_head_rd", wb_rd, 1);
    chk("credit_head_data", wb_data, 2);
    wb_ready = 1'b1;
    chk("credit_no_comb_ready", req_ready, 0);
    tick();
    chk("credit_rd2", wb_rd, 2);
    chk("credit_release", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("credit_rd3", wb_rd, 3);
    tick();
    chk("credit_rd4", wb_rd, 4);
    tick();
    wait_wb(20, n);
    chk("credit_rd5_valid", wb_valid, 1);
    chk("credit_rd5", wb_rd, 5);
    chk("credit_rd5_data", wb_data, 10);
    tick();
    chk("credit_drained", wb_valid, 0);
    chk("credit_outst", dut.outst, 0);

    // heap spacing
    drive(2'b01, 5'd3, 32'd9);
    chk("heap_push_ready", req_ready, 1);
    tick();
    chk("heap_c3_push", c3_push, 1);
    chk("heap_c3_push_data", c3_in_data, 9);
    drive(2'b10, 5'd4, 32'd0);
    chk("heap_pop_blocked", req_ready, 0);
    n = 1;
    while (req_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
      chk("heap_no_pop_early", c3_pop, 0);
    end
    chk("heap_gap", n, 13);
    tick();
    req_valid = 1'b0;
    chk("heap_c3_pop", c3_pop, 1);
    chk("heap_c3_push_off", c3_push, 0);
    tick();
    chk("heap_pop_pulse", c3_pop, 0);
    repeat (10) tick();
    chk("heap_outst", dut.outst, 0);

    // scoreboard hazard, same destination twice
    wb_ready = 1'b0;
    drive(2'b00, 5'd7, 32'd1);
    tick();
    drive(2'b00, 5'd7, 32'd2);
`ifdef C3_DISPATCH_SCOREBOARD_EN
    chk("sb_stall", req_ready, 0);
    chk("sb_busy", busy_mask, 32'h80);
    wait_wb(20, n);
    chk("sb_first_wb", wb_rd, 7);
    chk("sb_still_stall", req_ready, 0);
    chk("sb_busy_hold", busy_mask, 32'h80);
    wb_ready = 1'b1;
    tick();
    chk("sb_release", req_ready, 1);
    chk("sb_busy_clr", busy_mask, 0);
    tick();
    req_valid = 1'b0;
    chk("sb_busy_set2", busy_mask, 32'h80);
    wait_wb(20, n);
    chk("sb_second_wb", wb_data, 4);
    tick();
    chk("sb_busy_final", busy_mask, 0);
`else
    chk("sb_off_ready", req_ready, 1);
    chk("sb_off_busy", busy_mask, 0);
    tick();
    req_valid = 1'b0;
    wb_ready = 1'b1;
    wait_wb(20, n);
    chk("sb_off_wb1", wb_data, 2);
    tick();
    chk("sb_off_wb2", wb_data, 4);
    tick();
`endif
    repeat (3) tick();
    chk("sb_outst", dut.outst, 0);

    // rd 0 result is dropped and releases its credit
    drive(2'b00, 5'd0, 32'd5);
    tick();
    req_valid = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (wb_valid === 1'b1) seen = 1'b1;
    end
    chk("rd0_no_wb", seen, 0);
    chk("rd0_outst", dut.outst, 0);

    // unexpected result
    inj_v = 1'b1;
    inj_rd = 5'd9;
    inj_data = 32'hdead;
    tick();
    inj_v = 1'b0;
    chk("unexp_err", err_unexpected, 1);
    chk("unexp_no_wb", wb_valid, 0);
    tick();
    chk("unexp_sticky", err_unexpected, 1);
    chk("unexp_no_wb2", wb_valid, 0);

    // async reset mid-stream
    wb_ready = 1'b0;
    drive(2'b00, 5'd10, 32'd3);
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    drive(2'b00, 5'd11, 32'd4);
    tick();
    req_valid = 1'b0;
    chk("mid_wb_valid", wb_valid, 1);
    chk("mid_in_v", c3_in_v, 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_in_v", c3_in_v, 0);
    chk("arst_rd", c3_rd, 0);
    chk("arst_data", c3_in_data, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_err", err_unexpected, 0);
    chk("arst_busy", busy_mask, 0);
    chk("arst_outst", dut.outst, 0);
    tick();
    reset = 1'b0;
    chk("arst_ready", req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
